// File: rtl/iob_cache_req_arbiter_if.sv
// Bundle of the requester-side and cache-side IOb signals around the request arbiter.
// The slave modport is the arbiter's view; the master modport drives requesters and the cache.
interface iob_cache_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int NBYTES = DATA_W / 8
);
    logic [N_REQ-1:0]        s_valid;
    logic [N_REQ*ADDR_W-1:0] s_addr;
    logic [N_REQ*DATA_W-1:0] s_wdata;
    logic [N_REQ*NBYTES-1:0] s_wstrb;
    logic [DATA_W-1:0]       s_rdata;
    logic [N_REQ-1:0]        s_ready;

    logic                    m_valid;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic [NBYTES-1:0]       m_wstrb;
    logic [DATA_W-1:0]       m_rdata;
    logic                    m_ready;

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, m_rdata, m_ready,
        output s_rdata, s_ready, m_valid, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, m_rdata, m_ready,
        input  s_rdata, s_ready, m_valid, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/iob_cache_req_arbiter.sv
// Round-robin arbiter sharing one IOb cache frontend between N_REQ masters.
// The winning request is registered and held on the cache port until the cache answers.
module iob_cache_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int REQ_ID_W = $clog2(N_REQ),
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 512,
    parameter int NBYTES   = DATA_W / 8
) (
    input  logic                    ap_clk,
    input  logic                    reset,
    iob_cache_req_arbiter_if.slave  bus,
    output logic                    busy,
    output logic [REQ_ID_W-1:0]     grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic [REQ_ID_W-1:0] rr_ptr_q;
    logic [REQ_ID_W-1:0] grant_id_q;
    logic                busy_q;
    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [NBYTES-1:0]   m_wstrb_q;

    logic                win_found_d;
    logic [REQ_ID_W-1:0] win_id_d;
    logic [REQ_ID_W-1:0] rr_ptr_d;
    logic [N_REQ-1:0]    s_ready_d;

    // Scan requesters starting at rr_ptr, wrapping modulo N_REQ; first valid one wins.
    always_comb begin
        win_found_d = 1'b0;
        win_id_d    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!win_found_d && bus.s_valid[idx]) begin
                win_found_d = 1'b1;
                win_id_d    = REQ_ID_W'(idx);
            end else begin
                win_found_d = win_found_d;
            end
        end
    end

    // Pointer for the next search: one past the current winner, explicit wrap for non-power-of-2 N_REQ.
    always_comb begin
        if (grant_id_q == REQ_ID_W'(N_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_id_q + REQ_ID_W'(1);
        end
    end

    // Ready goes only to the current winner, and only in the cycle the cache answers.
    always_comb begin
        s_ready_d = '0;
        if ((state_q == BUSY) && bus.m_ready) begin
            s_ready_d[grant_id_q] = 1'b1;
        end else begin
            s_ready_d = '0;
        end
    end

    // Arbitration FSM with registered cache-port outputs.
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        m_addr_q   <= bus.s_addr[int'(win_id_d)*ADDR_W +: ADDR_W];
                        m_wdata_q  <= bus.s_wdata[int'(win_id_d)*DATA_W +: DATA_W];
                        m_wstrb_q  <= bus.s_wstrb[int'(win_id_d)*NBYTES +: NBYTES];
                        m_valid_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        grant_id_q <= win_id_d;
                        state_q    <= BUSY;
                    end else begin
                        m_valid_q  <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                BUSY: begin
                    // Requester inputs are deliberately ignored here; only the cache can end the transaction.
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= IDLE;
                    end else begin
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.s_ready = s_ready_d;
    assign bus.s_rdata = bus.m_rdata;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule
